// File: rtl/block_serial_adder.sv
// -----------------------------------------------------------------------------
// block_serial_adder
//
// Adds or subtracts two WIDTH-bit operands one BLOCK-bit slice per clock. The
// carry between slices is kept in a register. A start/busy/done handshake lets
// a controlling FSM launch one operation at a time.
//
// Subtraction computes a - b - c_in. It does this by adding ~b with carry-in
// ~c_in, so c_out = 0 means a borrow occurred.
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous active-high reset; aborts any operation in flight
//   start     request; sampled only in IDLE or DONE
//   sub       0 = add, 1 = subtract (latched with start)
//   a, b      operands (latched with start)
//   c_in      carry-in / borrow-in (latched with start)
//   busy      high while slices are processed (NBLK cycles)
//   done      one-cycle pulse when the results are valid
//   sum       result; holds until the next accepted start
//   c_out     carry out of the MSB
//   ovf       two's-complement signed overflow
//   skip_cnt  number of slices whose bits all propagate
// -----------------------------------------------------------------------------
module block_serial_adder #(
    parameter  int WIDTH = 16,
    parameter  int BLOCK = 4,
    localparam int NBLK  = WIDTH / BLOCK,
    localparam int CNTW  = $clog2(NBLK + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              sub,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic              c_in,
    output logic              busy,
    output logic              done,
    output logic [WIDTH-1:0]  sum,
    output logic              c_out,
    output logic              ovf,
    output logic [CNTW-1:0]   skip_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam logic [CNTW-1:0] LAST_K = CNTW'(NBLK - 1);

    state_t             state_r;
    state_t             next_state_s;
    logic               busy_nxt_s;
    logic               done_nxt_s;
    logic               accept_s;

    // Operand registers shift right by one slice per RUN cycle, so the
    // active slice always sits in the low BLOCK bits.
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic               carry_r;
    logic [CNTW-1:0]    k_r;

    logic [BLOCK-1:0]   a_sl_s;
    logic [BLOCK-1:0]   b_sl_s;
    logic [BLOCK:0]     slice_sum_s;
    logic               prop_s;
    logic               msb_carry_s;
    logic [WIDTH-1:0]   sum_shift_s;

    // A start is honoured only when no operation is in flight.
    assign accept_s = start && ((state_r == ST_IDLE) || (state_r == ST_DONE));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state logic.
    always_comb begin
        next_state_s = ST_IDLE;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (k_r == LAST_K) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    next_state_s = ST_RUN;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: begin
                next_state_s = ST_IDLE;
            end
        endcase
    end

    // Output decode, taken from the next state so that busy/done can be registered.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        case (next_state_s)
            ST_RUN: begin
                busy_nxt_s = 1'b1;
            end
            ST_DONE: begin
                done_nxt_s = 1'b1;
            end
            default: begin
                busy_nxt_s = 1'b0;
                done_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            busy <= busy_nxt_s;
            done <= done_nxt_s;
        end
    end

    // Slice adder and propagate detect for the current low slice.
    always_comb begin
        a_sl_s      = a_r[BLOCK-1:0];
        b_sl_s      = b_r[BLOCK-1:0];
        slice_sum_s = {1'b0, a_sl_s} + {1'b0, b_sl_s} + {{BLOCK{1'b0}}, carry_r};
        prop_s      = &(a_sl_s ^ b_sl_s);
        // Carry into the slice MSB, recovered from the sum bit and its operands.
        msb_carry_s = a_sl_s[BLOCK-1] ^ b_sl_s[BLOCK-1] ^ slice_sum_s[BLOCK-1];
        // The new slice enters at the top; after NBLK shifts, sum is aligned.
        sum_shift_s = sum >> BLOCK;
        sum_shift_s[WIDTH-1 -: BLOCK] = slice_sum_s[BLOCK-1:0];
    end

    // Datapath: latch on accept, then process one slice per RUN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r      <= {WIDTH{1'b0}};
            b_r      <= {WIDTH{1'b0}};
            carry_r  <= 1'b0;
            k_r      <= {CNTW{1'b0}};
            sum      <= {WIDTH{1'b0}};
            c_out    <= 1'b0;
            ovf      <= 1'b0;
            skip_cnt <= {CNTW{1'b0}};
        end else if (accept_s) begin
            a_r      <= a;
            b_r      <= sub ? ~b : b;
            carry_r  <= sub ? ~c_in : c_in;
            k_r      <= {CNTW{1'b0}};
            sum      <= {WIDTH{1'b0}};
            c_out    <= 1'b0;
            ovf      <= 1'b0;
            skip_cnt <= {CNTW{1'b0}};
        end else if (state_r == ST_RUN) begin
            a_r     <= a_r >> BLOCK;
            b_r     <= b_r >> BLOCK;
            carry_r <= slice_sum_s[BLOCK];
            sum     <= sum_shift_s;
            k_r     <= k_r + CNTW'(1);
            if (prop_s) begin
                skip_cnt <= skip_cnt + CNTW'(1);
            end
            if (k_r == LAST_K) begin
                c_out <= slice_sum_s[BLOCK];
                ovf   <= msb_carry_s ^ slice_sum_s[BLOCK];
            end
        end
    end

endmodule

// File: doc/block_serial_adder.md
Name: block_serial_adder

Overview:
- Sequential, parametrised successor to the combinational ripple and carry-skip adders.
- Adds or subtracts two WIDTH-bit operands one BLOCK-bit slice per clock, carrying between slices in a register.
- Reports per-slice propagate (skip) statistics and signed overflow.
- Used where area matters more than latency; start/busy/done handshake to a controlling FSM.

Parameters:
- WIDTH, 16, operand/result width in bits; must be an integer multiple of BLOCK.
- BLOCK, 4, bits processed per cycle (slice width).
- NBLK (localparam), WIDTH/BLOCK, number of slices = RUN cycles.
- CNTW (localparam), $clog2(NBLK+1), width of skip_cnt.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE or DONE.
- sub  input  1  0 = add, 1 = subtract; latched with start.
- a  input  WIDTH  operand A; latched with start.
- b  input  WIDTH  operand B; latched with start.
- c_in  input  1  carry-in (add) or borrow-in (sub); latched with start.
- busy  output  1  high while slices are being processed.
- done  output  1  one-cycle pulse; results valid.
- sum  output  WIDTH  result.
- c_out  output  1  carry out of MSB (sub: 0 = borrow occurred).
- ovf  output  1  two's-complement signed overflow.
- skip_cnt  output  CNTW  number of slices whose bits all propagate.

Behaviour:
- Reset (async, any time): state = IDLE; busy, done, sum, c_out, ovf, skip_cnt = 0; internal operand, carry and slice-index registers = 0. Reset during RUN aborts the operation; no done is produced.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge E0 starts an operation:
  - latch A = a; B' = sub ? ~b : b; carry = sub ? ~c_in : c_in (sub computes a - b - c_in).
  - clear sum and skip_cnt to 0; slice index k = 0; go to RUN.
- RUN: at each edge, for slice k (bits k*BLOCK+BLOCK-1 : k*BLOCK):
  - {carry, sum slice} = A slice + B' slice + carry.
  - P = AND of (A ^ B') over the slice; if P, skip_cnt += 1.
  - k += 1. When k == NBLK-1 is processed (edge E0+NBLK): c_out = final carry; ovf = carry into MSB XOR carry out of MSB; go to DONE.
- busy = 1 exactly from E0 to E0+NBLK (NBLK cycles), registered.
- DONE: done = 1 for exactly one cycle (E0+NBLK to E0+NBLK+1), busy = 0.
  - Next edge: start=1 is accepted exactly as in IDLE (back-to-back, no idle gap); otherwise go to IDLE.
  - done falls either way.
- start while in RUN is ignored; the operation in flight is unaffected. Inputs a, b, sub and c_in are don't-care except at the accepting edge.
- sum, c_out, ovf and skip_cnt hold their final values through DONE and IDLE until the next accepted start. Intermediate sum values during RUN are not guaranteed meaningful.
- Latency: start edge to done = NBLK cycles; throughput one result per NBLK+1 cycles.
- No wrap beyond WIDTH: the carry out of the MSB appears only on c_out. skip_cnt maximum is NBLK and never wraps.

Test Plan:
- Add, WIDTH=16, BLOCK=4: a=16'h1234, b=16'h1111, c_in=0, sub=0 -> busy for 4 cycles; done pulse on 5th; sum=16'h2345, c_out=0, ovf=0, skip_cnt=0.
- Full propagate: a=16'hFFFF, b=16'h0000, c_in=1, sub=0 -> sum=16'h0000, c_out=1, ovf=0, skip_cnt=4.
- Subtract: a=16'h0005, b=16'h0007, c_in=0, sub=1 -> sum=16'hFFFE, c_out=0 (borrow), ovf=0, skip_cnt=3.
- Signed overflow: a=16'h7FFF, b=16'h0001, c_in=0, sub=0 -> sum=16'h8000, c_out=0, ovf=1, skip_cnt=2.
- Handshake: start held high throughout RUN -> ignored. Start high in DONE cycle -> new operation begins next edge; done pulses exactly once per operation; results from the second operation are correct.
- Reset mid-op: assert rst 2 cycles after start -> all outputs 0 immediately, no done. A fresh start afterwards (a=16'h0001, b=16'h0001) -> sum=16'h0002, done after 4 cycles.
